// File: rtl/nand_cycle_engine.sv
// Clocked NAND bus cycle generator: command/address/write/read cycles with counted strobe timing.
// Optional macro NAND_RB_TIMEOUT_EN adds a TO_CYCLES bound on the R/B wait.
//
// state   | meaning
// IDLE    | ready for a request; nCE kept low only after a held cycle
// SETUP   | select target, set CLE/ALE and data bus
// WE_LO   | nWE low for T_WP clocks
// WE_HI   | nWE high for T_WH clocks, bus and latches held
// RE_LO   | nRE low for T_RP clocks, io_in sampled on exit
// RE_HI   | nRE high for T_REH clocks, rsp_valid on first clock
// WAIT_WB | T_WB clocks before R/B is trusted
// WAIT_RB | wait for synchronised R/B ready
module nand_cycle_engine #(
    parameter int IO_W      = 8,
    parameter int NUM_CE    = 1,
    parameter int T_WP      = 2,
    parameter int T_WH      = 2,
    parameter int T_RP      = 2,
    parameter int T_REH     = 2,
    parameter int T_WB      = 4,
    parameter int TO_CYCLES = 65535,
    localparam int CE_W     = (NUM_CE > 1) ? $clog2(NUM_CE) : 1
) (
    input  logic              clk,
    input  logic              nRST,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic [1:0]        req_type,
    input  logic [IO_W-1:0]   req_data,
    input  logic [CE_W-1:0]   req_ce,
    input  logic              req_hold,
    input  logic              req_wait,
    output logic              rsp_valid,
    output logic [IO_W-1:0]   rsp_data,
    output logic              err_ce,
    output logic              rb_timeout,
    input  logic              wp_n_in,
    output logic [NUM_CE-1:0] nCE,
    output logic              CLE,
    output logic              ALE,
    output logic              nWE,
    output logic              nRE,
    output logic              nWP,
    output logic [IO_W-1:0]   io_out,
    output logic              io_oe,
    input  logic [IO_W-1:0]   io_in,
    input  logic              RB
);

    typedef enum logic [2:0] {
        IDLE, SETUP, WE_LO, WE_HI, RE_LO, RE_HI, WAIT_WB, WAIT_RB
    } state_t;

    localparam int TMR_W = 16;

    // Timers hold (clocks - 1) and run down to a terminal count of zero.
    function automatic logic [TMR_W-1:0] tload(input int t);
        return (t < 2) ? '0 : TMR_W'(t - 1);
    endfunction

    localparam logic [TMR_W-1:0] LD_WP  = tload(T_WP);
    localparam logic [TMR_W-1:0] LD_WH  = tload(T_WH);
    localparam logic [TMR_W-1:0] LD_RP  = tload(T_RP);
    localparam logic [TMR_W-1:0] LD_REH = tload(T_REH);
    localparam logic [TMR_W-1:0] LD_WB  = tload(T_WB);
    localparam logic [CE_W:0]    CE_LIM = (CE_W + 1)'(NUM_CE);

    state_t            state_q, state_d;
    logic [TMR_W-1:0]  tmr_q, tmr_d;
    logic [1:0]        type_q;
    logic [IO_W-1:0]   data_q;
    logic [CE_W-1:0]   ce_q;
    logic              ce_ok_q, hold_q, wait_q;
    logic              rb_meta, rb_s;
    logic              accept, ce_ok_in, timeout;

    logic [1:0]        f_type;
    logic [IO_W-1:0]   f_data;
    logic [CE_W-1:0]   f_ce;
    logic              f_ok;
    logic [NUM_CE-1:0] sel_n;

    logic [NUM_CE-1:0] nce_d;
    logic              cle_d, ale_d, nwe_d, nre_d, oe_d, ready_d, rsp_v_d;
    logic [IO_W-1:0]   io_d, rsp_data_d;

    assign accept   = req_valid && req_ready;
    assign ce_ok_in = {1'b0, req_ce} < CE_LIM;

`ifdef NAND_RB_TIMEOUT_EN
    localparam logic [31:0] TO_LIM = (TO_CYCLES < 1) ? 32'd1 : 32'(TO_CYCLES);
    logic [31:0] to_cnt_q;

    always_ff @(posedge clk or negedge nRST) begin
        if (!nRST)                   to_cnt_q <= '0;
        else if (state_q != WAIT_RB) to_cnt_q <= '0;
        else if (!rb_s)              to_cnt_q <= to_cnt_q + 32'd1;
    end

    assign timeout = (state_q == WAIT_RB) && !rb_s && (to_cnt_q == TO_LIM - 32'd1);
`else
    assign timeout = 1'b0;
`endif

    // Fields of the cycle being issued: the live request on the accept edge, the latched copy after.
    always_comb begin
        f_type = accept ? req_type : type_q;
        f_data = accept ? req_data : data_q;
        f_ce   = accept ? req_ce   : ce_q;
        f_ok   = accept ? ce_ok_in : ce_ok_q;
        sel_n  = '1;
        for (int i = 0; i < NUM_CE; i++)
            if (f_ok && f_ce == CE_W'(i)) sel_n[i] = 1'b0;
    end

    always_comb begin
        state_d = state_q;
        tmr_d   = tmr_q;
        case (state_q)
            IDLE:    if (accept) state_d = SETUP;
            SETUP:   if (type_q == 2'd3) begin state_d = RE_LO; tmr_d = LD_RP; end
                     else                begin state_d = WE_LO; tmr_d = LD_WP; end
            WE_LO:   if (tmr_q == '0) begin state_d = WE_HI; tmr_d = LD_WH; end
                     else tmr_d = tmr_q - TMR_W'(1);
            RE_LO:   if (tmr_q == '0) begin state_d = RE_HI; tmr_d = LD_REH; end
                     else tmr_d = tmr_q - TMR_W'(1);
            WE_HI, RE_HI:
                     if (tmr_q == '0) begin
                         if (wait_q) begin state_d = WAIT_WB; tmr_d = LD_WB; end
                         else state_d = IDLE;
                     end else tmr_d = tmr_q - TMR_W'(1);
            WAIT_WB: if (tmr_q == '0) state_d = WAIT_RB;
                     else tmr_d = tmr_q - TMR_W'(1);
            WAIT_RB: if (rb_s || timeout) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Pin values are computed for the coming state and registered, so pins change with the state.
    always_comb begin
        nce_d      = nCE;
        cle_d      = 1'b0;
        ale_d      = 1'b0;
        nwe_d      = 1'b1;
        nre_d      = 1'b1;
        oe_d       = 1'b0;
        io_d       = io_out;
        ready_d    = (state_d == IDLE);
        rsp_v_d    = (state_q == RE_LO) && (state_d == RE_HI);
        rsp_data_d = rsp_data;
        case (state_d)
            SETUP, WE_LO, WE_HI, RE_LO, RE_HI: begin
                nce_d = sel_n;
                cle_d = (f_type == 2'd0);
                ale_d = (f_type == 2'd1);
                oe_d  = (f_type != 2'd3);
                io_d  = f_data;
                nwe_d = (state_d != WE_LO);
                nre_d = (state_d != RE_LO);
            end
            WAIT_WB, WAIT_RB: nce_d = sel_n;
            default: if (state_q != IDLE) nce_d = (hold_q && !timeout) ? sel_n : '1;
        endcase
        if (rsp_v_d) rsp_data_d = ce_ok_q ? io_in : '0;
    end

    always_ff @(posedge clk or negedge nRST) begin
        if (!nRST) begin
            state_q    <= IDLE;
            tmr_q      <= '0;
            type_q     <= '0;
            data_q     <= '0;
            ce_q       <= '0;
            ce_ok_q    <= 1'b0;
            hold_q     <= 1'b0;
            wait_q     <= 1'b0;
            rb_meta    <= 1'b0;
            rb_s       <= 1'b0;
            nCE        <= '1;
            CLE        <= 1'b0;
            ALE        <= 1'b0;
            nWE        <= 1'b1;
            nRE        <= 1'b1;
            nWP        <= 1'b0;
            io_out     <= '0;
            io_oe      <= 1'b0;
            req_ready  <= 1'b0;
            rsp_valid  <= 1'b0;
            rsp_data   <= '0;
            err_ce     <= 1'b0;
            rb_timeout <= 1'b0;
        end else begin
            state_q    <= state_d;
            tmr_q      <= tmr_d;
            rb_meta    <= RB;
            rb_s       <= rb_meta;
            if (accept) begin
                type_q  <= req_type;
                data_q  <= req_data;
                ce_q    <= req_ce;
                ce_ok_q <= ce_ok_in;
                hold_q  <= req_hold;
                wait_q  <= req_wait;
            end
            nCE        <= nce_d;
            CLE        <= cle_d;
            ALE        <= ale_d;
            nWE        <= nwe_d;
            nRE        <= nre_d;
            nWP        <= wp_n_in;
            io_out     <= io_d;
            io_oe      <= oe_d;
            req_ready  <= ready_d;
            rsp_valid  <= rsp_v_d;
            rsp_data   <= rsp_data_d;
            err_ce     <= accept && !ce_ok_in;
            rb_timeout <= timeout;
        end
    end

endmodule

// File: tb/tb_nand_cycle_engine.sv
// Directed vector bench for nand_cycle_engine (three targets, default strobe timing).
module tb_nand_cycle_engine;

    localparam int IO_W   = 8;
    localparam int NUM_CE = 3;
    localparam int CE_W   = 2;

    logic              clk = 1'b0;
    logic              nRST;
    logic              req_valid, req_ready;
    logic [1:0]        req_type;
    logic [IO_W-1:0]   req_data;
    logic [CE_W-1:0]   req_ce;
    logic              req_hold, req_wait;
    logic              rsp_valid;
    logic [IO_W-1:0]   rsp_data;
    logic              err_ce, rb_timeout, wp_n_in;
    logic [NUM_CE-1:0] nCE;
    logic              CLE, ALE, nWE, nRE, nWP, io_oe, RB;
    logic [IO_W-1:0]   io_out, io_in;

    nand_cycle_engine #(
        .IO_W(IO_W), .NUM_CE(NUM_CE), .T_WP(2), .T_WH(2), .T_RP(2), .T_REH(2),
        .T_WB(4), .TO_CYCLES(100)
    ) dut (
        .clk(clk), .nRST(nRST),
        .req_valid(req_valid), .req_ready(req_ready), .req_type(req_type),
        .req_data(req_data), .req_ce(req_ce), .req_hold(req_hold), .req_wait(req_wait),
        .rsp_valid(rsp_valid), .rsp_data(rsp_data), .err_ce(err_ce), .rb_timeout(rb_timeout),
        .wp_n_in(wp_n_in), .nCE(nCE), .CLE(CLE), .ALE(ALE), .nWE(nWE), .nRE(nRE),
        .nWP(nWP), .io_out(io_out), .io_oe(io_oe), .io_in(io_in), .RB(RB)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [1:0]  typ;
        logic [7:0]  data;
        logic [1:0]  ce;
        logic        hold;
        logic        wt;
        logic [7:0]  din;
        logic        e_cle, e_ale, e_oe;
        logic [2:0]  e_nce, e_idle;
        int          e_err, e_we, e_re, e_rsp;
        logic [7:0]  e_rd;
        int          e_rdy;
    } vec_t;

    vec_t vt[12];
    int   checks = 0;
    int   errors = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual 0x%0h required 0x%0h", nm, act, exp);
        end
    endtask

    function automatic vec_t mk(input logic [1:0] typ, input logic [7:0] data, input logic [1:0] ce,
                                input logic hold, input logic wt, input logic [7:0] din,
                                input logic cle, input logic ale, input logic oe,
                                input logic [2:0] nce, input logic [2:0] idle, input int err,
                                input int we, input int re, input int rsp, input logic [7:0] rd,
                                input int rdy);
        vec_t v;
        v.typ = typ; v.data = data; v.ce = ce; v.hold = hold; v.wt = wt; v.din = din;
        v.e_cle = cle; v.e_ale = ale; v.e_oe = oe; v.e_nce = nce; v.e_idle = idle;
        v.e_err = err; v.e_we = we; v.e_re = re; v.e_rsp = rsp; v.e_rd = rd; v.e_rdy = rdy;
        return v;
    endfunction

    // Called at a negedge with the engine idle; returns at the negedge where req_ready is back.
    task automatic run_vec(input int idx, input vec_t v);
        int we = 0, re = 0, rsp = 0, rsp_c = 0, err = 0, rdy = 99;
        logic [7:0] rd = '0;
        chk($sformatf("v%0d_ready_pre", idx), req_ready, 1);
        req_valid = 1'b1; req_type = v.typ; req_data = v.data; req_ce = v.ce;
        req_hold = v.hold; req_wait = v.wt; io_in = v.din;
        @(negedge clk);
        req_valid = 1'b0;
        for (int c = 1; c <= 40; c++) begin
            if (c > 1) @(negedge clk);
            if (c == 1) begin
                chk($sformatf("v%0d_cle", idx), CLE, v.e_cle);
                chk($sformatf("v%0d_ale", idx), ALE, v.e_ale);
                chk($sformatf("v%0d_oe", idx), io_oe, v.e_oe);
                chk($sformatf("v%0d_nce", idx), nCE, v.e_nce);
                if (v.typ != 2'd3) chk($sformatf("v%0d_io", idx), io_out, v.data);
            end
            chk($sformatf("v%0d_one_ce_c%0d", idx, c), ($countones(~nCE) <= 1), 1);
            if (!nWE) we++;
            if (!nRE) re++;
            if (err_ce) err++;
            if (rsp_valid) begin rsp++; rsp_c = c; rd = rsp_data; end
            if (req_ready) begin rdy = c; break; end
        end
        chk($sformatf("v%0d_we_lo", idx), we, v.e_we);
        chk($sformatf("v%0d_re_lo", idx), re, v.e_re);
        chk($sformatf("v%0d_err", idx), err, v.e_err);
        chk($sformatf("v%0d_rsp_cnt", idx), rsp, v.e_rsp);
        chk($sformatf("v%0d_ready_lat", idx), rdy, v.e_rdy);
        chk($sformatf("v%0d_nce_idle", idx), nCE, v.e_idle);
        chk($sformatf("v%0d_cle_idle", idx), CLE | ALE | io_oe, 0);
        if (v.e_rsp > 0) begin
            chk($sformatf("v%0d_rsp_at", idx), rsp_c, 4);
            chk($sformatf("v%0d_rsp_data", idx), rd, v.e_rd);
        end
    endtask

    initial begin
        int seen, lat;
        //            typ  data   ce hold wt din    cle ale oe nce     idle   err we re rsp rd     rdy
        vt[0]  = mk(2'd0, 8'hFF, 0, 0, 0, 8'h00, 1, 0, 1, 3'b110, 3'b111, 0, 2, 0, 0, 8'h00, 6);
        vt[1]  = mk(2'd1, 8'h00, 0, 1, 0, 8'h00, 0, 1, 1, 3'b110, 3'b110, 0, 2, 0, 0, 8'h00, 6);
        vt[2]  = mk(2'd1, 8'h01, 0, 1, 0, 8'h00, 0, 1, 1, 3'b110, 3'b110, 0, 2, 0, 0, 8'h00, 6);
        vt[3]  = mk(2'd1, 8'h02, 0, 1, 0, 8'h00, 0, 1, 1, 3'b110, 3'b110, 0, 2, 0, 0, 8'h00, 6);
        vt[4]  = mk(2'd2, 8'h5A, 1, 0, 0, 8'h00, 0, 0, 1, 3'b101, 3'b111, 0, 2, 0, 0, 8'h00, 6);
        vt[5]  = mk(2'd3, 8'h00, 0, 0, 0, 8'hA5, 0, 0, 0, 3'b110, 3'b111, 0, 0, 2, 1, 8'hA5, 6);
        vt[6]  = mk(2'd3, 8'h00, 3, 0, 0, 8'h3C, 0, 0, 0, 3'b111, 3'b111, 1, 0, 2, 1, 8'h00, 6);
        vt[7]  = mk(2'd0, 8'h70, 3, 0, 0, 8'h00, 1, 0, 1, 3'b111, 3'b111, 1, 2, 0, 0, 8'h00, 6);
        vt[8]  = mk(2'd3, 8'h00, 2, 0, 0, 8'h81, 0, 0, 0, 3'b011, 3'b111, 0, 0, 2, 1, 8'h81, 6);
        vt[9]  = mk(2'd1, 8'h33, 2, 1, 0, 8'h00, 0, 1, 1, 3'b011, 3'b011, 0, 2, 0, 0, 8'h00, 6);
        vt[10] = mk(2'd0, 8'h10, 0, 0, 0, 8'h00, 1, 0, 1, 3'b110, 3'b111, 0, 2, 0, 0, 8'h00, 6);
        // R/B already ready: SETUP 1 + WE 4 + WAIT_WB 4 + WAIT_RB 1, ready on clock 11.
        vt[11] = mk(2'd0, 8'h30, 1, 0, 1, 8'h00, 1, 0, 1, 3'b101, 3'b111, 0, 2, 0, 0, 8'h00, 11);

        nRST = 1'b0; req_valid = 1'b0; req_type = '0; req_data = '0; req_ce = '0;
        req_hold = 1'b0; req_wait = 1'b0; wp_n_in = 1'b1; io_in = '0; RB = 1'b1;

        repeat (3) @(negedge clk);
        chk("rst_nce", nCE, 3'b111);
        chk("rst_strobes", {CLE, ALE, nWE, nRE, nWP, io_oe}, 6'b001100);
        chk("rst_io_out", io_out, 0);
        chk("rst_ready", req_ready, 0);
        chk("rst_pulses", {rsp_valid, err_ce, rb_timeout}, 0);
        chk("rst_rsp_data", rsp_data, 0);

        nRST = 1'b1;
        @(negedge clk);
        chk("rel_ready", req_ready, 1);
        chk("rel_nwp", nWP, 1);
        wp_n_in = 1'b0;
        #1 chk("wp_hold", nWP, 1);
        @(negedge clk);
        chk("wp_follow", nWP, 0);
        wp_n_in = 1'b1;
        @(negedge clk);

        for (int i = 0; i < 12; i++) run_vec(i, vt[i]);

        // R/B held busy: engine must park in WAIT_RB until the synchronised rise.
        RB = 1'b0;
        repeat (3) @(negedge clk);
        req_valid = 1'b1; req_type = 2'd0; req_data = 8'h30; req_ce = 2'd0;
        req_hold = 1'b0; req_wait = 1'b1;
        @(negedge clk);
        req_valid = 1'b0;
        chk("rb_io", io_out, 8'h30);
        seen = 0;
        for (int c = 1; c <= 20; c++) begin
            if (c > 1) @(negedge clk);
            if (req_ready) seen++;
        end
        chk("rb_busy_hold", seen, 0);
        RB = 1'b1;
        lat = 99;
        for (int n = 1; n <= 10; n++) begin
            @(negedge clk);
            if (req_ready) begin lat = n; break; end
        end
        chk("rb_rise_lat", lat, 3);
        chk("rb_nce_idle", nCE, 3'b111);

        // Asynchronous reset while parked in WAIT_RB with a held target.
        RB = 1'b0;
        repeat (3) @(negedge clk);
        req_valid = 1'b1; req_type = 2'd0; req_data = 8'h70; req_ce = 2'd0;
        req_hold = 1'b1; req_wait = 1'b1;
        @(negedge clk);
        req_valid = 1'b0;
        repeat (11) @(negedge clk);
        chk("wait_nce", nCE, 3'b110);
        chk("wait_ready", req_ready, 0);
        #2 nRST = 1'b0;
        #1;
        chk("mid_rst_nce", nCE, 3'b111);
        chk("mid_rst_pins", {CLE, ALE, nWE, nRE, nWP, io_oe, req_ready}, 7'b0011000);
        chk("mid_rst_io", io_out, 0);
        @(negedge clk);
        nRST = 1'b1; RB = 1'b1;
        @(negedge clk);
        chk("post_rst_ready", req_ready, 1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog actual timeout required finish");
        $fatal(1, "watchdog");
    end

endmodule
